// File: rtl/vote_pkg.sv
// Shared definitions for the multi-candidate voting controller.
//   state_t      : controller FSM states (IDLE / CHECK / VOTE)
//   REJ_*        : reject_code values presented alongside the reject pulse
//   REJ_W        : width of reject_code
//   csel_width() : candidate-select width, max(1, clog2(num_cand))
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    VOTE  = 2'd2
  } state_t;

  localparam int REJ_W = 3;

  localparam logic [REJ_W-1:0] REJ_NONE     = 3'd0;
  localparam logic [REJ_W-1:0] REJ_CLOSED   = 3'd1;
  localparam logic [REJ_W-1:0] REJ_BAD_ID   = 3'd2;
  localparam logic [REJ_W-1:0] REJ_DUP_ID   = 3'd3;
  localparam logic [REJ_W-1:0] REJ_BAD_CAND = 3'd4;
  localparam logic [REJ_W-1:0] REJ_TIMEOUT  = 3'd5;

  function automatic int csel_width(input int num_cand);
    return (num_cand <= 2) ? 1 : $clog2(num_cand);
  endfunction

endpackage

// File: rtl/vote_tally_bank.sv
// Per-candidate saturating tally counters plus a saturating grand total.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (clears all counts)
//   inc          : increment strobe; bumps tally[inc_idx] and total_votes
//   inc_idx      : candidate to increment (caller guarantees < NUM_CAND)
//   rd_idx       : readout select
//   rd_count     : tally[rd_idx], combinational; 0 when rd_idx >= NUM_CAND
//   total_votes  : saturating sum of all increments
module vote_tally_bank #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int CSEL_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inc,
  input  logic [CSEL_W-1:0]         inc_idx,
  input  logic [CSEL_W-1:0]         rd_idx,
  output logic [CNT_W-1:0]          rd_count,
  output logic [CNT_W+CSEL_W-1:0]   total_votes
);

  localparam int TOT_W = CNT_W + CSEL_W;

  logic [CNT_W-1:0] tally [NUM_CAND];

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  function automatic logic [TOT_W-1:0] sat_inc_tot(input logic [TOT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        tally[i] <= '0;
      end
      total_votes <= '0;
    end else if (inc) begin
      tally[inc_idx] <= sat_inc_cnt(tally[inc_idx]);
      total_votes    <= sat_inc_tot(total_votes);
    end
  end

  // Out-of-range selects read as zero instead of aliasing another candidate.
  always_comb begin
    rd_count = '0;
    if ({1'b0, rd_idx} < (CSEL_W + 1)'(NUM_CAND)) begin
      rd_count = tally[rd_idx];
    end
  end

endmodule

// File: rtl/vote_ctrl_multi.sv
// Multi-candidate voting controller: session FSM, per-voter "already voted"
// bitmap, vote-window timer and poll-open gate, feeding a tally bank.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   poll_open           : level, voting allowed
//   check, id           : start a session for voter id (ignored while busy)
//   id_valid            : whitelist verdict for the latched id, used in CHECK
//   vote_signal         : cast a vote for cand_sel (only honoured in VOTE)
//   cand_sel            : candidate index
//   busy                : session in progress
//   vote_enable         : ballot lamp, high while in VOTE
//   vote_done           : 1-cycle pulse, vote accepted
//   current_candidate   : candidate counted, valid with vote_done
//   reject, reject_code : 1-cycle pulse and reason for an aborted session
//   rd_cand, rd_count   : combinational tally readout
//   total_votes         : saturating total of accepted votes
module vote_ctrl_multi
  import vote_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int ID_W     = 4,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 16,
  localparam int CSEL_W  = csel_width(NUM_CAND)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     poll_open,
  input  logic                     check,
  input  logic [ID_W-1:0]          id,
  input  logic                     id_valid,
  input  logic                     vote_signal,
  input  logic [CSEL_W-1:0]        cand_sel,
  output logic                     busy,
  output logic                     vote_enable,
  output logic                     vote_done,
  output logic [CSEL_W-1:0]        current_candidate,
  output logic                     reject,
  output logic [REJ_W-1:0]         reject_code,
  input  logic [CSEL_W-1:0]        rd_cand,
  output logic [CNT_W-1:0]         rd_count,
  output logic [CNT_W+CSEL_W-1:0]  total_votes
);

  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int NUM_ID = 2 ** ID_W;

  state_t              state, state_n;
  logic [ID_W-1:0]     id_q, id_n;
  logic [TMR_W-1:0]    timer, timer_n;
  logic [NUM_ID-1:0]   used;
  logic                mark;
  logic                inc;
  logic                cand_ok;
  logic                vote_done_n;
  logic                reject_n;
  logic [REJ_W-1:0]    code_n;
  logic [CSEL_W-1:0]   cand_n;

  assign cand_ok = ({1'b0, cand_sel} < (CSEL_W + 1)'(NUM_CAND));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Decision logic. In VOTE the priority is: valid vote, bad candidate,
  // poll closed, timer expiry -- so a vote on the expiry edge still counts.
  always_comb begin
    state_n     = state;
    id_n        = id_q;
    timer_n     = timer;
    vote_done_n = 1'b0;
    reject_n    = 1'b0;
    code_n      = REJ_NONE;
    cand_n      = current_candidate;
    inc         = 1'b0;
    mark        = 1'b0;
    case (state)
      IDLE: begin
        if (check) begin
          if (poll_open) begin
            id_n    = id;
            state_n = CHECK;
          end else begin
            reject_n = 1'b1;
            code_n   = REJ_CLOSED;
          end
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (!id_valid) begin
          reject_n = 1'b1;
          code_n   = REJ_BAD_ID;
        end else if (used[id_q]) begin
          reject_n = 1'b1;
          code_n   = REJ_DUP_ID;
        end else begin
          state_n = VOTE;
          timer_n = TMR_W'(TIMEOUT);
        end
      end
      VOTE: begin
        if (vote_signal && cand_ok) begin
          inc         = 1'b1;
          mark        = 1'b1;
          vote_done_n = 1'b1;
          cand_n      = cand_sel;
          state_n     = IDLE;
        end else if (vote_signal) begin
          // Bad candidate leaves the ID unused so the voter can retry.
          reject_n = 1'b1;
          code_n   = REJ_BAD_CAND;
          state_n  = IDLE;
        end else if (!poll_open) begin
          reject_n = 1'b1;
          code_n   = REJ_CLOSED;
          state_n  = IDLE;
        end else if (timer <= TMR_W'(1)) begin
          // Timer holds the number of VOTE edges still allowed; this edge is the last.
          reject_n = 1'b1;
          code_n   = REJ_TIMEOUT;
          state_n  = IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs and session context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q              <= '0;
      timer             <= '0;
      used              <= '0;
      busy              <= 1'b0;
      vote_enable       <= 1'b0;
      vote_done         <= 1'b0;
      reject            <= 1'b0;
      reject_code       <= REJ_NONE;
      current_candidate <= '0;
    end else begin
      id_q              <= id_n;
      timer             <= timer_n;
      if (mark) begin
        used[id_q] <= 1'b1;
      end
      busy              <= (state_n != IDLE);
      vote_enable       <= (state_n == VOTE);
      vote_done         <= vote_done_n;
      reject            <= reject_n;
      reject_code       <= code_n;
      current_candidate <= cand_n;
    end
  end

  vote_tally_bank #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W),
    .CSEL_W   (CSEL_W)
  ) u_tally (
    .clk         (clk),
    .reset       (reset),
    .inc         (inc),
    .inc_idx     (cand_sel),
    .rd_idx      (rd_cand),
    .rd_count    (rd_count),
    .total_votes (total_votes)
  );

endmodule

// File: tb/tb_vote_ctrl_multi.sv
// Scoreboard bench for vote_ctrl_multi: stimulus tasks push expected pulses
// (kind, code/candidate, cycle) into a queue; a negedge monitor pops them.
`timescale 1ns/1ps
module tb_vote_ctrl_multi;

  localparam int NUM_CAND = 5;
  localparam int ID_W     = 5;
  localparam int CNT_W    = 2;
  localparam int TIMEOUT  = 16;
  localparam int CSEL_W   = (NUM_CAND <= 2) ? 1 : $clog2(NUM_CAND);
  localparam int TOT_W    = CNT_W + CSEL_W;
  localparam int NUM_ID   = 2 ** ID_W;
  localparam int CNT_MAX  = 2 ** CNT_W - 1;
  localparam int TOT_MAX  = 2 ** TOT_W - 1;

  localparam int C_CLOSED = 1, C_BAD_ID = 2, C_DUP_ID = 3, C_BAD_CAND = 4, C_TIMEOUT = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              poll_open = 1'b1;
  logic              check = 1'b0;
  logic [ID_W-1:0]   id = '0;
  logic              id_valid = 1'b0;
  logic              vote_signal = 1'b0;
  logic [CSEL_W-1:0] cand_sel = '0;
  logic              busy, vote_enable, vote_done, reject;
  logic [CSEL_W-1:0] current_candidate;
  logic [2:0]        reject_code;
  logic [CSEL_W-1:0] rd_cand = '0;
  logic [CNT_W-1:0]  rd_count;
  logic [TOT_W-1:0]  total_votes;

  vote_ctrl_multi #(
    .NUM_CAND (NUM_CAND),
    .ID_W     (ID_W),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .poll_open         (poll_open),
    .check             (check),
    .id                (id),
    .id_valid          (id_valid),
    .vote_signal       (vote_signal),
    .cand_sel          (cand_sel),
    .busy              (busy),
    .vote_enable       (vote_enable),
    .vote_done         (vote_done),
    .current_candidate (current_candidate),
    .reject            (reject),
    .reject_code       (reject_code),
    .rd_cand           (rd_cand),
    .rd_count          (rd_count),
    .total_votes       (total_votes)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit done;
    int code;
    int cand;
    int at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  bit used_m [NUM_ID];
  int tally_m [NUM_CAND];
  int total_m;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat_inc(input int x, input int mx);
    return (x >= mx) ? mx : x + 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_ID; i++) used_m[i] = 1'b0;
    for (int c = 0; c < NUM_CAND; c++) tally_m[c] = 0;
    total_m = 0;
  endtask

  task automatic push_rej(input int code, input int at);
    exp_t e;
    e.done = 1'b0; e.code = code; e.cand = 0; e.at = at;
    sb.push_back(e);
  endtask

  task automatic push_done(input int cand, input int at);
    exp_t e;
    e.done = 1'b1; e.code = 0; e.cand = cand; e.at = at;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expectation, at the right cycle.
  exp_t got;
  always @(negedge clk) begin
    if (!reset && (vote_done || reject)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: vote_done=%0d reject=%0d code=%0d at cycle %0d, none expected",
                 vote_done, reject, reject_code, cyc);
      end else begin
        got = sb.pop_front();
        chk("pulse_exclusive", int'(vote_done & reject), 0);
        chk("pulse_kind_done", int'(vote_done), int'(got.done));
        chk("pulse_cycle", cyc, got.at);
        if (got.done) chk("current_candidate", int'(current_candidate), got.cand);
        else          chk("reject_code", int'(reject_code), got.code);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_tallies();
    for (int c = 0; c < 2 ** CSEL_W; c++) begin
      rd_cand = CSEL_W'(c);
      #1;
      chk($sformatf("rd_count[%0d]", c), int'(rd_count), (c < NUM_CAND) ? tally_m[c] : 0);
    end
    chk("total_votes", int'(total_votes), total_m);
  endtask

  task automatic apply_reset();
    step();
    step();
    reset = 1'b1;
    step();
    step();
    model_clear();
    chk("reset_busy", int'(busy), 0);
    chk("reset_vote_enable", int'(vote_enable), 0);
    chk("reset_vote_done", int'(vote_done), 0);
    chk("reset_reject", int'(reject), 0);
    check_tallies();
    reset = 1'b0;
    step();
  endtask

  // One voter session. vote_at / drop_at count VOTE edges from entry (0 = never).
  task automatic session(input int sid, input bit idv, input bit open_at_check,
                         input int vote_at, input int cs, input int drop_at);
    int t0, e_cyc, tdec;
    bit is_vote;
    t0 = cyc;
    poll_open   = open_at_check;
    check       = 1'b1;
    id          = ID_W'(sid);
    id_valid    = idv;
    vote_signal = 1'($urandom % 2);
    cand_sel    = CSEL_W'($urandom);
    if (!open_at_check) begin
      push_rej(C_CLOSED, t0 + 1);
      step();
      check = 1'b0; vote_signal = 1'b0; poll_open = 1'b1;
      chk("closed_idle_busy", int'(busy), 0);
      return;
    end
    step();
    poll_open = 1'b1;
    chk("check_busy", int'(busy), 1);
    chk("check_vote_enable", int'(vote_enable), 0);
    check       = 1'($urandom % 2);
    id          = ID_W'($urandom);
    vote_signal = 1'($urandom % 2);
    if (!idv) begin
      push_rej(C_BAD_ID, t0 + 2);
    end else if (used_m[sid]) begin
      push_rej(C_DUP_ID, t0 + 2);
    end
    step();
    check = 1'b0; vote_signal = 1'b0;
    if (!idv || used_m[sid]) begin
      chk("after_check_busy", int'(busy), 0);
      return;
    end
    e_cyc = cyc;
    chk("vote_entry_enable", int'(vote_enable), 1);
    // Decide the outcome from the rules: vote > closed poll > expiry.
    tdec = TIMEOUT;
    is_vote = 1'b0;
    for (int t = 1; t <= TIMEOUT; t++) begin
      if (vote_at == t) begin
        tdec = t;
        is_vote = 1'b1;
        break;
      end else if (drop_at != 0 && t >= drop_at) begin
        tdec = t;
        break;
      end
    end
    if (is_vote) begin
      if (cs < NUM_CAND) begin
        push_done(cs, e_cyc + tdec);
        used_m[sid] = 1'b1;
        tally_m[cs] = sat_inc(tally_m[cs], CNT_MAX);
        total_m     = sat_inc(total_m, TOT_MAX);
      end else begin
        push_rej(C_BAD_CAND, e_cyc + tdec);
      end
    end else if (drop_at != 0 && drop_at <= tdec) begin
      push_rej(C_CLOSED, e_cyc + tdec);
    end else begin
      push_rej(C_TIMEOUT, e_cyc + tdec);
    end
    for (int t = 1; t <= tdec; t++) begin
      vote_signal = (t == vote_at);
      cand_sel    = (t == vote_at) ? CSEL_W'(cs) : CSEL_W'($urandom);
      poll_open   = !(drop_at != 0 && t >= drop_at);
      check       = 1'($urandom % 2);
      id          = ID_W'($urandom);
      step();
    end
    vote_signal = 1'b0; check = 1'b0; poll_open = 1'b1;
    chk("exit_vote_enable", int'(vote_enable), 0);
    chk("exit_busy", int'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    reset = 1'b1;
    #1;
    chk("init_busy", int'(busy), 0);
    chk("init_reject", int'(reject), 0);
    apply_reset();

    // Basic vote, duplicate, bad ID, bad candidate and retry
    session(3, 1, 1, 2, 2, 0);
    check_tallies();
    session(3, 1, 1, 2, 2, 0);
    check_tallies();
    session(5, 0, 1, 1, 1, 0);
    session(5, 1, 1, 1, 7, 0);
    session(5, 1, 1, 1, 1, 0);
    check_tallies();

    // Timeout, vote on the expiry edge, vote beyond the window
    session(6, 1, 1, 0, 0, 0);
    session(7, 1, 1, TIMEOUT, 0, 0);
    session(8, 1, 1, TIMEOUT + 1, 0, 0);
    check_tallies();

    // Poll closed from IDLE, closed mid-VOTE then retry, drop and vote on same edge
    session(9, 1, 0, 1, 3, 0);
    session(9, 1, 1, 5, 3, 3);
    session(9, 1, 1, 1, 3, 0);
    session(10, 1, 1, 4, 4, 4);
    check_tallies();

    // Saturation of candidate 0
    for (int v = 11; v < 15; v++) session(v, 1, 1, 1, 0, 0);
    check_tallies();
    session(11, 1, 1, 1, 0, 0);

    // Reset in the middle of a VOTE window with a vote on the same cycle
    step();
    step();
    poll_open = 1'b1; check = 1'b1; id = ID_W'(30); id_valid = 1'b1;
    step();
    check = 1'b0;
    step();
    chk("pre_reset_vote_enable", int'(vote_enable), 1);
    step();
    vote_signal = 1'b1; cand_sel = '0;
    reset = 1'b1;
    #1;
    chk("midvote_reset_busy", int'(busy), 0);
    chk("midvote_reset_vote_enable", int'(vote_enable), 0);
    step();
    vote_signal = 1'b0;
    model_clear();
    check_tallies();
    reset = 1'b0;
    step();
    chk("post_reset_busy", int'(busy), 0);
    session(30, 1, 1, 1, 0, 0);
    check_tallies();

    // Every ID votes once: total saturates
    apply_reset();
    for (int v = 0; v < NUM_ID; v++) session(v, 1, 1, 1 + v % 3, v % NUM_CAND, 0);
    check_tallies();

    // Randomized sessions
    apply_reset();
    for (int n = 0; n < 90; n++) begin
      int sid, vat, cs, drop, r;
      bit idv, opn;
      sid  = $urandom_range(0, NUM_ID - 1);
      idv  = ($urandom % 6) != 0;
      opn  = ($urandom % 8) != 0;
      r    = $urandom % 10;
      vat  = (r < 7) ? $urandom_range(1, 6) : (r < 8) ? 0 : $urandom_range(TIMEOUT - 1, TIMEOUT + 1);
      cs   = (($urandom % 4) == 0) ? $urandom_range(NUM_CAND, 2 ** CSEL_W - 1) : $urandom_range(0, NUM_CAND - 1);
      drop = (($urandom % 6) == 0) ? $urandom_range(1, 8) : 0;
      session(sid, idv, opn, vat, cs, drop);
      for (int g = 0; g < int'($urandom % 3); g++) begin
        vote_signal = 1'($urandom % 2);
        cand_sel    = CSEL_W'($urandom);
        step();
      end
      vote_signal = 1'b0;
      check_tallies();
    end

    step();
    step();
    step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
